// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing one wide SRAM read port among NUM_REQ requesters.
// Tracks each issued read through the fixed SRAM latency and returns data tagged with ID and address.
module sram_read_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_BITS      = $clog2(NUM_REQ),
   parameter int ADDR_BITS    = 10,
   parameter int DATA_BITS    = 8,
   parameter int UNIT_LEN     = 64,
   parameter int READ_LATENCY = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cke,
   input  logic [NUM_REQ-1:0]             s_req,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   s_addr,
   output logic [NUM_REQ-1:0]             s_grant,
   output logic                           mem_ren,
   output logic [ADDR_BITS-1:0]           mem_raddr,
   input  logic [UNIT_LEN*DATA_BITS-1:0]  mem_rdata,
   output logic [ID_BITS-1:0]             m_id,
   output logic [ADDR_BITS-1:0]           m_addr,
   output logic [UNIT_LEN*DATA_BITS-1:0]  m_data,
   output logic                           m_valid
);

   localparam int DW = UNIT_LEN * DATA_BITS;

   logic [ID_BITS-1:0]   ptr_q;
   logic [ID_BITS-1:0]   gnt_idx;
   logic [ID_BITS-1:0]   cand;
   logic                 gnt_any;
   logic [ADDR_BITS-1:0] gnt_addr;

   logic                 mem_ren_q;
   logic [ADDR_BITS-1:0] mem_raddr_q, mem_raddr_d;

   // Stage 0 is the issue tag (aligned with mem_ren); stage READ_LATENCY is aligned with mem_rdata.
   logic [READ_LATENCY:0]                tag_v_q;
   logic [READ_LATENCY:0][ID_BITS-1:0]   tag_id_q;
   logic [READ_LATENCY:0][ADDR_BITS-1:0] tag_addr_q;

   logic                 m_valid_q;
   logic [ID_BITS-1:0]   m_id_q;
   logic [ADDR_BITS-1:0] m_addr_q;
   logic [DW-1:0]        m_data_q;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = ID_BITS'((int'(ptr_q) + k) % NUM_REQ);
         if (!gnt_any && s_req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (reset || !cke) begin
         gnt_any = 1'b0;
      end
      s_grant     = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
      gnt_addr    = s_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
      mem_raddr_d = gnt_any ? gnt_addr : mem_raddr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= ID_BITS'(NUM_REQ - 1);
         mem_ren_q   <= 1'b0;
         mem_raddr_q <= '0;
         tag_v_q     <= '0;
         tag_id_q    <= '0;
         tag_addr_q  <= '0;
         m_valid_q   <= 1'b0;
         m_id_q      <= '0;
         m_addr_q    <= '0;
         m_data_q    <= '0;
      end else if (cke) begin
         mem_ren_q   <= gnt_any;
         mem_raddr_q <= mem_raddr_d;
         if (gnt_any) begin
            ptr_q <= gnt_idx;
         end
         for (int unsigned s = READ_LATENCY; s >= 1; s--) begin
            tag_v_q[s]    <= tag_v_q[s-1];
            tag_id_q[s]   <= tag_id_q[s-1];
            tag_addr_q[s] <= tag_addr_q[s-1];
         end
         tag_v_q[0]    <= gnt_any;
         tag_id_q[0]   <= gnt_idx;
         tag_addr_q[0] <= gnt_addr;
         m_valid_q     <= tag_v_q[READ_LATENCY];
         if (tag_v_q[READ_LATENCY]) begin
            m_data_q <= mem_rdata;
            m_id_q   <= tag_id_q[READ_LATENCY];
            m_addr_q <= tag_addr_q[READ_LATENCY];
         end
      end
   end

   assign mem_ren   = mem_ren_q;
   assign mem_raddr = mem_raddr_q;
   assign m_valid   = m_valid_q;
   assign m_id      = m_id_q;
   assign m_addr    = m_addr_q;
   assign m_data    = m_data_q;

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Round-robin arbiter that shares one wide SRAM read port among NUM_REQ requesters (array engines, debug readers).
- Issues at most one read per clock-enabled cycle.
- Tracks each read through the fixed SRAM read latency and returns the data with the winning requester's ID and address.
- Sits between requester logic and the array SRAM, alongside the sram-to-sram read pipelines.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_BITS, $clog2(NUM_REQ), width of the returned requester ID
- ADDR_BITS, 10, SRAM address width
- DATA_BITS, 8, element width (signed)
- UNIT_LEN, 64, elements per SRAM word
- READ_LATENCY, 2, cycles from a mem_ren cycle to the cycle mem_rdata is valid (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cke  in  1  clock enable; when low, all state holds and no grant is issued
- s_req  in  NUM_REQ  per-requester read request; held until granted
- s_addr  in  NUM_REQ×ADDR_BITS  per-requester read address; held with s_req
- s_grant  out  NUM_REQ  one-hot combinational grant; transfer = s_req[i] & s_grant[i] & cke
- mem_ren  out  1  SRAM read enable (registered)
- mem_raddr  out  ADDR_BITS  SRAM read address (registered)
- mem_rdata  in  UNIT_LEN×DATA_BITS  SRAM read data, valid READ_LATENCY cycles after the mem_ren cycle
- m_id  out  ID_BITS  requester index of the returned data
- m_addr  out  ADDR_BITS  address of the returned data
- m_data  out  UNIT_LEN×DATA_BITS  returned read data (registered)
- m_valid  out  1  return strobe, one cycle per granted read

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous, active-high. It clears mem_ren, m_valid and all tag-pipe valids to 0. mem_raddr, m_id, m_addr and m_data reset to 0. The round-robin pointer resets to NUM_REQ-1, so requester 0 has priority first.
- Arbitration (combinational):
  - When cke=1, grant the lowest-indexed requesting i, searching circularly from ptr+1 to ptr (mod NUM_REQ).
  - s_grant is all-zero when cke=0, during reset, or when there are no requests.
  - s_grant never depends on s_addr.
- Pointer update: on a transfer, ptr <= granted index. Otherwise ptr holds.
- Issue stage: on each cke edge, mem_ren <= (any transfer), mem_raddr <= s_addr[granted], and the issue tag (id, addr, valid) <= the same values.
- Tag pipe:
  - READ_LATENCY register stages carry {valid, id, addr}.
  - All stages advance only on cke.
  - On the cke edge of the cycle where the last tag stage is valid, the return register captures m_data <= mem_rdata, m_id, m_addr, and m_valid <= 1. Otherwise m_valid <= 0 and the data registers hold.
- Latency: transfer in cycle t → mem_ren high in cycle t+1 → m_valid high in cycle t+2+READ_LATENCY (t+4 at default). Every cycle in this count is a cke=1 cycle.
- Throughput: one read per cke cycle. Returns come back in issue order with no reordering and no back-pressure; the consumer must accept m_valid whenever it is asserted.
- cke=0: registers, pointer and tags freeze. The SRAM is on the same cke, so the returned data stays aligned with its tag.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- A requester that drops s_req before its grant loses nothing; no state is kept for it.
- Reset mid-operation: in-flight tags are discarded and no m_valid pulse follows reset. The pointer returns to NUM_REQ-1.
- Wrap-around: the circular search crosses index NUM_REQ-1 → 0 without a bubble.

Test Plan:
- Reset release, s_req=0001, s_addr[0]=0x055 → s_grant=0001 in the same cycle; mem_ren=1 with raddr 0x055 at t+1; m_valid=1 with m_id=0 and m_addr=0x055 at t+4; m_data equals the model's word at 0x055.
- s_req=1111 held for 8 cycles → grant sequence 0,1,2,3,0,1,2,3; 8 m_valid pulses on consecutive cycles starting at t+4, IDs in the same order.
- Only requester 2 requesting continuously for 5 cycles → granted every cycle, 5 back-to-back m_valid pulses, addresses in request order.
- Transfers at t and t+1 with cke=0 for 3 cycles starting at t+2 → m_valid pulses delayed by exactly 3 cycles; data still matches each address.
- Pointer at 3 (last grant = 3), s_req=1001 → grant 0, then 3; no idle cycle between.
- Async reset asserted mid-cycle with 3 reads in flight → mem_ren and m_valid drop immediately; no m_valid after release; the first post-reset grant goes to the lowest-indexed requester.
